// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
//   Shared types and helpers for the load/store unit:
//   - state_t       : transaction FSM states
//   - F3_*          : RV32I funct3 encodings for loads/stores
//   - ERR_*         : fault codes reported on o_err
//   - access_fault  : illegal-size / misaligned classification of a request
//   - byte_mask     : byte enables for a given size and byte offset
//   - store_lanes   : store data replicated onto every lane of the size
// -----------------------------------------------------------------------------
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_WAIT = 2'b10,
    S_RESP = 2'b11
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

  // Illegal size is checked first so that an undefined funct3 is never
  // reported as misaligned.
  function automatic logic [1:0] access_fault(input logic       wren,
                                              input logic [2:0] funct3,
                                              input logic [1:0] off);
    logic legal;
    legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
            (!wren && ((funct3 == F3_BU) || (funct3 == F3_HU)));
    if (!legal)
      return ERR_ILLEGAL;
    if ((funct3[1:0] == 2'b01) && off[0])
      return ERR_MISALIGN;
    if ((funct3[1:0] == 2'b10) && (off != 2'b00))
      return ERR_MISALIGN;
    return ERR_NONE;
  endfunction

  function automatic logic [3:0] byte_mask(input logic [2:0] funct3,
                                           input logic [1:0] off);
    case (funct3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicating the datum onto every lane lets the byte mask alone pick the
  // destination, so no data shifter is needed.
  function automatic logic [31:0] store_lanes(input logic [2:0]  funct3,
                                              input logic [31:0] data);
    case (funct3[1:0])
      2'b00:   return {4{data[7:0]}};
      2'b01:   return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_extract.sv
// -----------------------------------------------------------------------------
// lsu_load_extract
//   Combinational load-data alignment and extension.
//   Ports:
//     rdata   in  32 : raw read word from memory
//     offset  in   2 : byte offset of the access within the word
//     funct3  in   3 : load size/sign (LB, LH, LW, LBU, LHU)
//     ld_data out 32 : word shifted right by 8*offset, then the low byte/half
//                      sign- or zero-extended; LW passes rdata unchanged
// -----------------------------------------------------------------------------
module lsu_load_extract
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] ld_data
);

  logic [15:0] low_half;

  // Only the low halfword of the shifted word is ever consumed.
  assign low_half = 16'(rdata >> {offset, 3'b000});

  // NOTE: ld_data gets a default before the case so every path assigns it
  // and no latch is inferred.
  always_comb begin
    ld_data = rdata;
    case (funct3)
      F3_B:    ld_data = {{24{low_half[7]}}, low_half[7:0]};
      F3_H:    ld_data = {{16{low_half[15]}}, low_half};
      F3_BU:   ld_data = {24'h0, low_half[7:0]};
      F3_HU:   ld_data = {16'h0, low_half};
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_access.sv
// -----------------------------------------------------------------------------
// lsu_mem_access
//   Load/store unit behind the ALU. Accepts one RV32I load or store, checks it
//   for illegal size / misalignment, runs it on the data-memory handshake and
//   returns a one-cycle response with extended load data and a fault code.
//   Ports:
//     i_clk, i_reset            : clock, asynchronous active-high reset
//     i_req_valid / o_req_ready : request handshake (ready only when idle)
//     i_wren, i_funct3, i_addr, i_st_data : request fields
//     o_mem_valid / i_mem_ready : memory request handshake
//     o_mem_addr, o_mem_we, o_mem_bmask, o_mem_wdata : memory request fields
//     i_mem_rvalid, i_mem_rdata : memory read return
//     o_rsp_valid               : one-cycle completion pulse
//     o_ld_data, o_err          : result and fault, nonzero only with rsp
//   All outputs are registered.
// -----------------------------------------------------------------------------
module lsu_mem_access
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ADDR_W         = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_wren,
  input  logic [2:0]        i_funct3,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_st_data,
  output logic              o_mem_valid,
  input  logic              i_mem_ready,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_we,
  output logic [3:0]        o_mem_bmask,
  output logic [31:0]       o_mem_wdata,
  input  logic              i_mem_rvalid,
  input  logic [31:0]       i_mem_rdata,
  output logic              o_rsp_valid,
  output logic [31:0]       o_ld_data,
  output logic [1:0]        o_err
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             wren_q;
  logic [2:0]       f3_q;
  logic [1:0]       off_q;
  logic [31:0]      ext_data;
  logic [1:0]       req_fault;

  assign req_fault = access_fault(i_wren, i_funct3, i_addr[1:0]);

  lsu_load_extract u_extract (
    .rdata   (i_mem_rdata),
    .offset  (off_q),
    .funct3  (f3_q),
    .ld_data (ext_data)
  );

  // NOTE: all state and registered outputs use non-blocking assignments so
  // every branch sees the values from the start of the cycle.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      wren_q      <= 1'b0;
      f3_q        <= 3'b000;
      off_q       <= 2'b00;
      o_req_ready <= 1'b1;
      o_mem_valid <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_we    <= 1'b0;
      o_mem_bmask <= 4'b0000;
      o_mem_wdata <= 32'h0;
      o_rsp_valid <= 1'b0;
      o_ld_data   <= 32'h0;
      o_err       <= ERR_NONE;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_req_valid && o_req_ready) begin
            wren_q      <= i_wren;
            f3_q        <= i_funct3;
            off_q       <= i_addr[1:0];
            o_req_ready <= 1'b0;
            if (req_fault != ERR_NONE) begin
              // Faulting requests never reach the memory bus.
              o_err       <= req_fault;
              o_rsp_valid <= 1'b1;
              state       <= S_RESP;
            end else begin
              o_mem_valid <= 1'b1;
              o_mem_addr  <= {i_addr[ADDR_W-1:2], 2'b00};
              o_mem_we    <= i_wren;
              o_mem_bmask <= byte_mask(i_funct3, i_addr[1:0]);
              o_mem_wdata <= i_wren ? store_lanes(i_funct3, i_st_data) : 32'h0;
              cnt         <= '0;
              state       <= S_REQ;
            end
          end
        end

        S_REQ: begin
          // A handshake in the terminal count cycle still wins over timeout.
          if (i_mem_ready || (cnt == CNT_MAX)) begin
            o_mem_valid <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_we    <= 1'b0;
            o_mem_bmask <= 4'b0000;
            o_mem_wdata <= 32'h0;
          end
          if (i_mem_ready) begin
            if (wren_q) begin
              o_rsp_valid <= 1'b1;
              state       <= S_RESP;
            end else begin
              // rvalid is not looked at here, so read data coincident with
              // the request handshake is ignored.
              cnt   <= '0;
              state <= S_WAIT;
            end
          end else if (cnt == CNT_MAX) begin
            o_err       <= ERR_TIMEOUT;
            o_rsp_valid <= 1'b1;
            state       <= S_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_WAIT: begin
          if (i_mem_rvalid) begin
            o_ld_data   <= ext_data;
            o_rsp_valid <= 1'b1;
            state       <= S_RESP;
          end else if (cnt == CNT_MAX) begin
            o_err       <= ERR_TIMEOUT;
            o_rsp_valid <= 1'b1;
            state       <= S_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_RESP: begin
          // Result fields are only meaningful alongside the pulse.
          o_rsp_valid <= 1'b0;
          o_ld_data   <= 32'h0;
          o_err       <= ERR_NONE;
          o_req_ready <= 1'b1;
          state       <= S_IDLE;
        end

        default: begin
          state       <= S_IDLE;
          o_req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_access.sv
// -----------------------------------------------------------------------------
// tb_lsu_mem_access
//   Directed, table-driven bench for lsu_mem_access. Each record carries the
//   request, the memory behaviour and the hand-computed response; a small
//   table also exercises lsu_load_extract on its own. Hand-written sequences
//   cover reset during a pending load.
// -----------------------------------------------------------------------------
module tb_lsu_mem_access;
  import lsu_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_wren;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr;
  logic [31:0] i_st_data;
  logic        o_mem_valid;
  logic        i_mem_ready;
  logic [31:0] o_mem_addr;
  logic        o_mem_we;
  logic [3:0]  o_mem_bmask;
  logic [31:0] o_mem_wdata;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;
  logic        o_rsp_valid;
  logic [31:0] o_ld_data;
  logic [1:0]  o_err;

  logic [31:0] x_rdata;
  logic [1:0]  x_off;
  logic [2:0]  x_f3;
  logic [31:0] x_ld;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 i_clk = ~i_clk;

  lsu_mem_access #(.TIMEOUT_CYCLES(16), .ADDR_W(32)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_wren       (i_wren),
    .i_funct3     (i_funct3),
    .i_addr       (i_addr),
    .i_st_data    (i_st_data),
    .o_mem_valid  (o_mem_valid),
    .i_mem_ready  (i_mem_ready),
    .o_mem_addr   (o_mem_addr),
    .o_mem_we     (o_mem_we),
    .o_mem_bmask  (o_mem_bmask),
    .o_mem_wdata  (o_mem_wdata),
    .i_mem_rvalid (i_mem_rvalid),
    .i_mem_rdata  (i_mem_rdata),
    .o_rsp_valid  (o_rsp_valid),
    .o_ld_data    (o_ld_data),
    .o_err        (o_err)
  );

  lsu_load_extract u_x (
    .rdata   (x_rdata),
    .offset  (x_off),
    .funct3  (x_f3),
    .ld_data (x_ld)
  );

  typedef struct {
    logic        wren;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] st;
    logic [31:0] rdata;
    logic        mem_rdy;   // memory ready held high
    logic        give_rv;   // memory returns rvalid one cycle after handshake
    logic [1:0]  err;
    logic        mem;       // o_mem_valid expected at some point
    logic [3:0]  bmask;
    logic [31:0] wdata;
    logic [31:0] ld;
    int          lat;       // cycles from acceptance to o_rsp_valid
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  off;
    logic [2:0]  f3;
    logic [31:0] ld;
  } xvec_t;

  localparam int NV = 14;
  localparam int NX = 5;
  vec_t  vecs[NV];
  xvec_t xvecs[NX];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic wren, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] st, input logic [31:0] rdata,
                              input logic mem_rdy, input logic give_rv, input logic [1:0] err,
                              input logic mem, input logic [3:0] bmask, input logic [31:0] wdata,
                              input logic [31:0] ld, input int lat);
    vec_t v;
    v.wren = wren; v.f3 = f3; v.addr = addr; v.st = st; v.rdata = rdata;
    v.mem_rdy = mem_rdy; v.give_rv = give_rv; v.err = err; v.mem = mem;
    v.bmask = bmask; v.wdata = wdata; v.ld = ld; v.lat = lat;
    return v;
  endfunction

  // Called at posedge+1 of an idle cycle; returns at posedge+1 of the idle
  // cycle following the response so the next request can go out at once.
  task automatic run_vec(input vec_t v, input int idx);
    logic        saw_mem, got_rsp, rv_pending, ready_bad, mem_in_rsp;
    logic [31:0] m_addr, m_wdata, r_ld;
    logic [3:0]  m_bmask;
    logic        m_we;
    logic [1:0]  r_err;
    int          lat;
    saw_mem = 0; got_rsp = 0; rv_pending = 0; ready_bad = 0; mem_in_rsp = 0;
    m_addr = 0; m_wdata = 0; m_bmask = 0; m_we = 0; r_ld = 0; r_err = 0; lat = 0;
    i_mem_ready = v.mem_rdy;
    i_req_valid = 1'b1;
    i_wren      = v.wren;
    i_funct3    = v.f3;
    i_addr      = v.addr;
    i_st_data   = v.st;
    for (int c = 1; c <= 40 && !got_rsp; c++) begin
      @(posedge i_clk); #1;
      i_req_valid  = 1'b0;
      i_mem_rvalid = 1'b0;
      if (rv_pending) begin
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = v.rdata;
        rv_pending   = 1'b0;
      end
      if (o_req_ready) ready_bad = 1'b1;
      if (o_mem_valid && !saw_mem) begin
        saw_mem = 1'b1;
        m_addr = o_mem_addr; m_we = o_mem_we; m_bmask = o_mem_bmask; m_wdata = o_mem_wdata;
      end
      if (o_mem_valid && i_mem_ready && !v.wren && v.give_rv) rv_pending = 1'b1;
      if (o_rsp_valid) begin
        got_rsp = 1'b1; lat = c; r_err = o_err; r_ld = o_ld_data; mem_in_rsp = o_mem_valid;
      end
    end
    check($sformatf("v%0d latency", idx), lat, v.lat);
    check($sformatf("v%0d err", idx), {30'h0, r_err}, {30'h0, v.err});
    check($sformatf("v%0d ld_data", idx), r_ld, v.ld);
    check($sformatf("v%0d mem_valid_seen", idx), {31'h0, saw_mem}, {31'h0, v.mem});
    check($sformatf("v%0d busy_ready_low", idx), {31'h0, ready_bad}, 32'h0);
    check($sformatf("v%0d mem_valid_in_rsp", idx), {31'h0, mem_in_rsp}, 32'h0);
    if (v.mem) begin
      check($sformatf("v%0d mem_addr", idx), m_addr, {v.addr[31:2], 2'b00});
      check($sformatf("v%0d mem_we", idx), {31'h0, m_we}, {31'h0, v.wren});
      if (v.wren) begin
        check($sformatf("v%0d bmask", idx), {28'h0, m_bmask}, {28'h0, v.bmask});
        check($sformatf("v%0d wdata", idx), m_wdata, v.wdata);
      end
    end
    @(posedge i_clk); #1;
    i_mem_rvalid = 1'b0;
    check($sformatf("v%0d after_rsp {rsp,ready,mvalid,err}", idx),
          {27'h0, o_rsp_valid, o_req_ready, o_mem_valid, o_err}, 32'h0000_0008);
    check($sformatf("v%0d after_rsp ld_data", idx), o_ld_data, 32'h0);
  endtask

  initial begin
    logic late_rsp;
    // Standalone load-extraction table.
    xvecs[0] = '{32'h1280FF34, 2'd2, F3_B,  32'hFFFFFF80};
    xvecs[1] = '{32'h1280FF34, 2'd1, F3_BU, 32'h000000FF};
    xvecs[2] = '{32'h1280FF34, 2'd0, F3_H,  32'hFFFFFF34};
    xvecs[3] = '{32'h1280FF34, 2'd2, F3_HU, 32'h00001280};
    xvecs[4] = '{32'h1280FF34, 2'd0, F3_W,  32'h1280FF34};

    //            wren f3      addr          st            rdata         rdy rv  err           mem bmask    wdata         ld            lat
    vecs[0]  = mk(1, F3_B,   32'h0000_1003, 32'h0000_00A5, 32'h0,        1, 0, ERR_NONE,     1, 4'b1000, 32'hA5A5A5A5, 32'h0,        2);
    vecs[1]  = mk(0, F3_B,   32'h0000_2002, 32'h0,        32'h1280FF34, 1, 1, ERR_NONE,     1, 4'b0000, 32'h0,        32'hFFFFFF80, 3);
    vecs[2]  = mk(0, F3_BU,  32'h0000_2002, 32'h0,        32'h1280FF34, 1, 1, ERR_NONE,     1, 4'b0000, 32'h0,        32'h00000080, 3);
    vecs[3]  = mk(0, F3_H,   32'h0000_2001, 32'h0,        32'h0,        1, 0, ERR_MISALIGN, 0, 4'b0000, 32'h0,        32'h0,        1);
    vecs[4]  = mk(0, 3'b011, 32'h0000_2000, 32'h0,        32'h0,        1, 0, ERR_ILLEGAL,  0, 4'b0000, 32'h0,        32'h0,        1);
    vecs[5]  = mk(1, F3_W,   32'h0000_4000, 32'hDEADBEEF, 32'h0,        1, 0, ERR_NONE,     1, 4'b1111, 32'hDEADBEEF, 32'h0,        2);
    vecs[6]  = mk(0, F3_HU,  32'h0000_4002, 32'h0,        32'hDEADBEEF, 1, 1, ERR_NONE,     1, 4'b0000, 32'h0,        32'h0000DEAD, 3);
    vecs[7]  = mk(1, F3_H,   32'h0000_5002, 32'h1234ABCD, 32'h0,        1, 0, ERR_NONE,     1, 4'b1100, 32'hABCDABCD, 32'h0,        2);
    vecs[8]  = mk(1, F3_BU,  32'h0000_5000, 32'h0,        32'h0,        1, 0, ERR_ILLEGAL,  0, 4'b0000, 32'h0,        32'h0,        1);
    vecs[9]  = mk(0, F3_W,   32'h0000_6002, 32'h0,        32'h0,        1, 0, ERR_MISALIGN, 0, 4'b0000, 32'h0,        32'h0,        1);
    vecs[10] = mk(1, F3_HU,  32'h0000_6001, 32'h0,        32'h0,        1, 0, ERR_ILLEGAL,  0, 4'b0000, 32'h0,        32'h0,        1);
    vecs[11] = mk(0, F3_H,   32'h0000_2006, 32'h0,        32'h80017FFF, 1, 1, ERR_NONE,     1, 4'b0000, 32'h0,        32'hFFFF8001, 3);
    vecs[12] = mk(0, F3_W,   32'h0000_3000, 32'h0,        32'h0,        1, 0, ERR_TIMEOUT,  1, 4'b0000, 32'h0,        32'h0,        18);
    vecs[13] = mk(0, F3_W,   32'h0000_3004, 32'h0,        32'h0,        0, 0, ERR_TIMEOUT,  1, 4'b0000, 32'h0,        32'h0,        17);

    i_reset = 1'b1; i_req_valid = 0; i_wren = 0; i_funct3 = 0; i_addr = 0; i_st_data = 0;
    i_mem_ready = 1; i_mem_rvalid = 0; i_mem_rdata = 0;
    x_rdata = 0; x_off = 0; x_f3 = 0;

    for (int i = 0; i < NX; i++) begin
      x_rdata = xvecs[i].rdata; x_off = xvecs[i].off; x_f3 = xvecs[i].f3;
      #1;
      check($sformatf("extract%0d", i), x_ld, xvecs[i].ld);
    end

    check("reset {rsp,ready,mvalid,we,err}",
          {26'h0, o_rsp_valid, o_req_ready, o_mem_valid, o_mem_we, o_err}, 32'h0000_0010);
    check("reset bmask/addr", {o_mem_bmask, o_mem_addr[27:0]}, 32'h0);
    @(posedge i_clk); #1;
    i_reset = 1'b0;

    for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

    // Reset while a load sits in S_WAIT; a late rvalid must not produce rsp.
    i_mem_ready = 1'b1;
    i_req_valid = 1'b1; i_wren = 1'b0; i_funct3 = F3_W; i_addr = 32'h0000_8000;
    @(posedge i_clk); #1;           // S_REQ, handshake at next edge
    i_req_valid = 1'b0;
    check("rst_seq mem_valid in S_REQ", {31'h0, o_mem_valid}, 32'h1);
    @(posedge i_clk); #1;           // S_WAIT
    #2 i_reset = 1'b1;
    #1;
    check("rst_seq async {rsp,ready,mvalid,err}",
          {27'h0, o_rsp_valid, o_req_ready, o_mem_valid, o_err}, 32'h0000_0008);
    check("rst_seq async mem_addr", o_mem_addr, 32'h0);
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    i_mem_rvalid = 1'b1; i_mem_rdata = 32'h5555_AAAA;
    late_rsp = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge i_clk); #1;
      i_mem_rvalid = 1'b0;
      if (o_rsp_valid) late_rsp = 1'b1;
    end
    check("rst_seq late rvalid rsp", {31'h0, late_rsp}, 32'h0);
    check("rst_seq idle ready", {31'h0, o_req_ready}, 32'h1);

    // Unit recovers and runs a normal store after the abandoned load.
    run_vec(vecs[0], 99);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
